// File: rtl/cache_store.sv
// cache_store: two-group set-associative tag/data store with power-up/flush invalidate sequencer.
// Optional macro CACHE_PAR_INJECT_EN adds inj_tag_par_h / inj_data_par_h diagnostic parity-inject ports.

module cache_store #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 14
) (
    input  logic                  b_clk_l,
    input  logic                  reset_h,
    input  logic                  lookup_h,
    input  logic [INDEX_BITS-1:0] index_h,
    input  logic [TAG_BITS-1:0]   tag_in_h,
    input  logic [31:0]           data_in_h,
    input  logic [1:0]            cache_grp_wr_h,
    input  logic [1:0]            cache_valid_h,
    input  logic [3:0]            ena_byte_l,
    input  logic                  flush_req_h,
`ifdef CACHE_PAR_INJECT_EN
    input  logic [1:0]            inj_tag_par_h,
    input  logic [1:0]            inj_data_par_h,
`endif
    output logic [31:0]           data_out_h,
    output logic [1:0]            hit_h,
    output logic [1:0]            tag_par_err_h,
    output logic                  data_par_err_l,
    output logic                  flush_busy_h
);

    localparam int SETS = 2**INDEX_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] flush_cnt;
    logic                  flushing;
    logic                  wr_en;

    logic [1:0]            inj_tag;
    logic [1:0]            inj_data;

    logic [1:0]            hit_c;
    logic [1:0]            tpe_c;
    logic [1:0]            dpe_c;
    logic [1:0][3:0]       byte_bad;
    logic [1:0][31:0]      rd_data;

    assign flushing = (state == ST_FLUSH);
    assign wr_en    = !reset_h && !flushing;

`ifdef CACHE_PAR_INJECT_EN
    assign inj_tag  = inj_tag_par_h;
    assign inj_data = inj_data_par_h;
`else
    assign inj_tag  = '0;
    assign inj_data = '0;
`endif

    // Arrays are read asynchronously at index_h and the results registered, so a
    // same-edge write is seen by the lookup only on the following access.
    for (genvar g = 0; g < 2; g++) begin : grp
        logic [SETS-1:0]     valid_mem;
        logic [TAG_BITS-1:0] tag_mem  [SETS];
        logic                tpar_mem [SETS];
        logic                grp_wr;
        logic                rd_valid;
        logic                rd_tpar;
        logic [TAG_BITS-1:0] rd_tag;

        assign grp_wr = wr_en && cache_grp_wr_h[g];

        always_ff @(posedge b_clk_l) begin
            if (!reset_h) begin
                if (flushing) begin
                    valid_mem[flush_cnt] <= 1'b0;
                end else if (cache_grp_wr_h[g]) begin
                    valid_mem[index_h] <= cache_valid_h[g];
                end
            end
        end

        always_ff @(posedge b_clk_l) begin
            if (grp_wr) begin
                tag_mem[index_h]  <= tag_in_h;
                tpar_mem[index_h] <= (~^{cache_valid_h[g], tag_in_h}) ^ inj_tag[g];
            end
        end

        assign rd_valid = valid_mem[index_h];
        assign rd_tag   = tag_mem[index_h];
        assign rd_tpar  = tpar_mem[index_h];

        assign tpe_c[g] = rd_valid & ~(^{rd_valid, rd_tag, rd_tpar});
        assign hit_c[g] = rd_valid & (rd_tag == tag_in_h) & ~tpe_c[g];
        assign dpe_c[g] = |byte_bad[g];

        for (genvar b = 0; b < 4; b++) begin : byt
            logic [7:0] byte_mem [SETS];
            logic       bpar_mem [SETS];

            always_ff @(posedge b_clk_l) begin
                if (grp_wr && !ena_byte_l[b]) begin
                    byte_mem[index_h] <= data_in_h[8*b +: 8];
                    bpar_mem[index_h] <= (~^data_in_h[8*b +: 8]) ^ inj_data[g];
                end
            end

            assign rd_data[g][8*b +: 8] = byte_mem[index_h];
            assign byte_bad[g][b]       = ~(^{byte_mem[index_h], bpar_mem[index_h]});
        end
    end

    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            state          <= ST_FLUSH;
            flush_cnt      <= '0;
            flush_busy_h   <= 1'b1;
            hit_h          <= '0;
            tag_par_err_h  <= '0;
            data_par_err_l <= 1'b1;
            data_out_h     <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + INDEX_BITS'(1);
                    if (flush_cnt == '1) begin
                        state        <= ST_IDLE;
                        flush_busy_h <= 1'b0;
                    end
                end
                default: begin
                    if (flush_req_h) begin
                        state        <= ST_FLUSH;
                        flush_cnt    <= '0;
                        flush_busy_h <= 1'b1;
                    end
                end
            endcase

            if (lookup_h) begin
                if (flushing) begin
                    hit_h          <= '0;
                    tag_par_err_h  <= '0;
                    data_par_err_l <= 1'b1;
                    data_out_h     <= '0;
                end else begin
                    hit_h          <= hit_c;
                    tag_par_err_h  <= tpe_c;
                    data_par_err_l <= ~|(hit_c & dpe_c);
                    data_out_h     <= hit_c[0] ? rd_data[0] :
                                      hit_c[1] ? rd_data[1] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_store.sv
// tb_cache_store: randomized self-checking bench for cache_store against a
// set-level behavioural model (flush modelled as an invalidate-all plus busy window).

module tb_cache_store;

    localparam int IB   = 8;
    localparam int TB   = 14;
    localparam int SETS = 2**IB;

    logic          b_clk_l = 1'b0;
    logic          reset_h;
    logic          lookup_h;
    logic [IB-1:0] index_h;
    logic [TB-1:0] tag_in_h;
    logic [31:0]   data_in_h;
    logic [1:0]    cache_grp_wr_h;
    logic [1:0]    cache_valid_h;
    logic [3:0]    ena_byte_l;
    logic          flush_req_h;
    logic [1:0]    inj_tag_par_h;
    logic [1:0]    inj_data_par_h;
    logic [31:0]   data_out_h;
    logic [1:0]    hit_h;
    logic [1:0]    tag_par_err_h;
    logic          data_par_err_l;
    logic          flush_busy_h;

    always #5 b_clk_l = ~b_clk_l;

    cache_store #(
        .INDEX_BITS(IB),
        .TAG_BITS  (TB)
    ) dut (
        .b_clk_l       (b_clk_l),
        .reset_h       (reset_h),
        .lookup_h      (lookup_h),
        .index_h       (index_h),
        .tag_in_h      (tag_in_h),
        .data_in_h     (data_in_h),
        .cache_grp_wr_h(cache_grp_wr_h),
        .cache_valid_h (cache_valid_h),
        .ena_byte_l    (ena_byte_l),
        .flush_req_h   (flush_req_h),
`ifdef CACHE_PAR_INJECT_EN
        .inj_tag_par_h (inj_tag_par_h),
        .inj_data_par_h(inj_data_par_h),
`endif
        .data_out_h    (data_out_h),
        .hit_h         (hit_h),
        .tag_par_err_h (tag_par_err_h),
        .data_par_err_l(data_par_err_l),
        .flush_busy_h  (flush_busy_h)
    );

    // Reference model state
    logic [TB-1:0] m_tag   [2][SETS];
    bit            m_valid [2][SETS];
    bit            m_tbad  [2][SETS];
    logic [7:0]    m_data  [2][SETS][4];
    bit            m_dbad  [2][SETS][4];
    int            flush_left;
    logic [1:0]    e_hit;
    logic [1:0]    e_tpe;
    logic          e_dpe_l;
    logic [31:0]   e_data;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", tag, $time, got, exp);
        end
    endtask

    task automatic clear_valid();
        for (int g = 0; g < 2; g++)
            for (int s = 0; s < SETS; s++)
                m_valid[g][s] = 1'b0;
    endtask

    task automatic check_outputs();
        chk("busy",    32'(flush_busy_h),   32'(flush_left > 0));
        chk("hit",     32'(hit_h),          32'(e_hit));
        chk("tag_par", 32'(tag_par_err_h),  32'(e_tpe));
        chk("dpe_l",   32'(data_par_err_l), 32'(e_dpe_l));
        chk("data",    data_out_h,          e_data);
    endtask

    task automatic do_reset();
        reset_h        = 1'b1;
        lookup_h       = 1'b0;
        cache_grp_wr_h = 2'b00;
        flush_req_h    = 1'b0;
        @(negedge b_clk_l);
        reset_h    = 1'b0;
        flush_left = SETS;
        clear_valid();
        e_hit   = 2'b00;
        e_tpe   = 2'b00;
        e_dpe_l = 1'b1;
        e_data  = '0;
        check_outputs();
    endtask

    // One clock: drive inputs, predict the edge, advance, compare.
    task automatic cyc(input bit lk, input logic [IB-1:0] idx, input logic [TB-1:0] tg,
                       input logic [31:0] d, input logic [1:0] wr, input logic [1:0] vld,
                       input logic [3:0] ena, input bit fr, input logic [1:0] it,
                       input logic [1:0] idt);
        logic [1:0] h;
        logic [1:0] tp;
        bit         any_bad;
        int         hg;
        lookup_h       = lk;
        index_h        = idx;
        tag_in_h       = tg;
        data_in_h      = d;
        cache_grp_wr_h = wr;
        cache_valid_h  = vld;
        ena_byte_l     = ena;
        flush_req_h    = fr;
        inj_tag_par_h  = it;
        inj_data_par_h = idt;

        if (lk) begin
            if (flush_left > 0) begin
                e_hit   = 2'b00;
                e_tpe   = 2'b00;
                e_dpe_l = 1'b1;
                e_data  = '0;
            end else begin
                any_bad = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    tp[g] = m_valid[g][idx] && m_tbad[g][idx];
                    h[g]  = m_valid[g][idx] && (m_tag[g][idx] == tg) && !tp[g];
                    if (h[g])
                        for (int b = 0; b < 4; b++)
                            if (m_dbad[g][idx][b]) any_bad = 1'b1;
                end
                e_hit   = h;
                e_tpe   = tp;
                e_dpe_l = !any_bad;
                hg = h[0] ? 0 : 1;
                e_data = (h != 2'b00) ? {m_data[hg][idx][3], m_data[hg][idx][2],
                                         m_data[hg][idx][1], m_data[hg][idx][0]} : 32'h0;
            end
        end

        if (flush_left > 0) begin
            flush_left--;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (wr[g]) begin
                    m_tag[g][idx]   = tg;
                    m_valid[g][idx] = vld[g];
                    m_tbad[g][idx]  = it[g];
                    for (int b = 0; b < 4; b++) begin
                        if (!ena[b]) begin
                            m_data[g][idx][b] = d[8*b +: 8];
                            m_dbad[g][idx][b] = idt[g];
                        end
                    end
                end
            end
            if (fr) begin
                flush_left = SETS;
                clear_valid();
            end
        end

        @(negedge b_clk_l);
        check_outputs();
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, 2'b00, 2'b00, 4'hF, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic look(input logic [IB-1:0] idx, input logic [TB-1:0] tg);
        cyc(1'b1, idx, tg, '0, 2'b00, 2'b00, 4'hF, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic drain_flush();
        for (int i = 0; i < 2*SETS && flush_left > 0; i++) idle();
    endtask

    logic [IB-1:0] pool   [8] = '{8'h00, 8'h01, 8'h05, 8'h12, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    logic [TB-1:0] tpool  [3] = '{14'h1ABC, 14'h0555, 14'h3FFF};

    initial begin
        int n;
        bit done;
        logic [IB-1:0] ri;
        logic [TB-1:0] rt;
        logic [1:0]    rw;
        logic [1:0]    rv;
        logic [3:0]    re;
        logic [1:0]    rit;
        logic [1:0]    rid;

        index_h = '0; tag_in_h = '0; data_in_h = '0; cache_valid_h = '0;
        ena_byte_l = 4'hF; inj_tag_par_h = '0; inj_data_par_h = '0;
        @(negedge b_clk_l);
        do_reset();

        // Power-up flush length, then a miss anywhere
        n = flush_busy_h ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 2*SETS && !done; i++) begin
            look(8'(i), 14'h1ABC);
            if (flush_busy_h) n++; else done = 1'b1;
        end
        chk("flush_len_pwrup", 32'(n), 32'(SETS));
        look(8'h33, 14'h0000);
        chk("pwrup_miss", 32'(hit_h), 32'h0);
        chk("pwrup_dpe_l", 32'(data_par_err_l), 32'h1);

        // Write/hit
        cyc(1'b0, 8'h12, 14'h1ABC, 32'hDEADBEEF, 2'b01, 2'b01, 4'h0, 1'b0, 2'b00, 2'b00);
        look(8'h12, 14'h1ABC);
        chk("wr_hit", 32'(hit_h), 32'h1);
        chk("wr_hit_data", data_out_h, 32'hDEADBEEF);
        look(8'h12, 14'h1ABD);
        chk("tag_miss", 32'(hit_h), 32'h0);

        // Partial byte write
        cyc(1'b0, 8'h05, 14'h0777, 32'h11223344, 2'b10, 2'b10, 4'h0, 1'b0, 2'b00, 2'b00);
        cyc(1'b0, 8'h05, 14'h0777, 32'hAAAAAAAA, 2'b10, 2'b10, 4'hA, 1'b0, 2'b00, 2'b00);
        look(8'h05, 14'h0777);
        chk("byte_hit", 32'(hit_h), 32'h2);
        chk("byte_data", data_out_h, 32'h11AA33AA);

        // Read-before-write: invalidate on the same edge as the lookup
        cyc(1'b1, 8'h12, 14'h1ABC, 32'h0, 2'b01, 2'b00, 4'h0, 1'b0, 2'b00, 2'b00);
        chk("rbw_old_hit", 32'(hit_h), 32'h1);
        look(8'h12, 14'h1ABC);
        chk("rbw_new_miss", 32'(hit_h), 32'h0);

`ifdef CACHE_PAR_INJECT_EN
        cyc(1'b0, 8'h20, 14'h0100, 32'h01020304, 2'b01, 2'b01, 4'h0, 1'b0, 2'b01, 2'b00);
        look(8'h20, 14'h0100);
        chk("inj_tpe", 32'(tag_par_err_h), 32'h1);
        chk("inj_tpe_hit", 32'(hit_h), 32'h0);
        cyc(1'b0, 8'h21, 14'h0200, 32'h55667788, 2'b10, 2'b10, 4'h0, 1'b0, 2'b00, 2'b10);
        look(8'h21, 14'h0200);
        chk("inj_dpe_hit", 32'(hit_h), 32'h2);
        chk("inj_dpe_l", 32'(data_par_err_l), 32'h0);
`endif

        // Random phase over a pool of fully initialised sets
        for (int i = 0; i < 8; i++)
            cyc(1'b0, pool[i], tpool[$urandom_range(0, 2)], $urandom, 2'b11,
                2'($urandom), 4'h0, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 800; i++) begin
            ri  = pool[$urandom_range(0, 7)];
            rt  = tpool[$urandom_range(0, 2)];
            rw  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            rv  = 2'($urandom);
            re  = 4'($urandom);
            rit = 2'b00;
            rid = 2'b00;
`ifdef CACHE_PAR_INJECT_EN
            if ($urandom_range(0, 9) == 0) begin
                rit = 2'($urandom);
                rid = 2'($urandom);
            end
`endif
            cyc(1'($urandom), ri, rt, $urandom, rw, rv, re,
                ($urandom_range(0, 299) == 0), rit, rid);
        end
        drain_flush();

        // Reset mid-flush: restart and ignore writes during the flush
        cyc(1'b0, 8'h12, 14'h1ABC, 32'hCAFEF00D, 2'b11, 2'b11, 4'h0, 1'b0, 2'b00, 2'b00);
        cyc(1'b0, '0, '0, '0, 2'b00, 2'b00, 4'hF, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 100; i++) idle();
        do_reset();
        n = flush_busy_h ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 2*SETS && !done; i++) begin
            cyc(1'b0, 8'h12, 14'h1ABC, $urandom, 2'b11, 2'b11, 4'h0, 1'b0, 2'b00, 2'b00);
            if (flush_busy_h) n++; else done = 1'b1;
        end
        chk("flush_len_restart", 32'(n), 32'(SETS));
        look(8'h12, 14'h1ABC);
        chk("flush_wr_ignored", 32'(hit_h), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete, got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_store.md
Name: cache_store

Overview:
- Two-group set-associative cache tag/data store, directly downstream of the cache control chip.
- Consumes `cache_grp_wr_h`, `cache_valid_h` and `ena_byte_l` from the control chip.
- Returns `hit_h`, `tag_par_err_h` and `data_par_err_l` for the next lookup.
- Contains a power-up/flush sequencer that invalidates every set.

Parameters:
- INDEX_BITS, 8, set index width; set count = 2**INDEX_BITS.
- TAG_BITS, 14, stored tag width per group.

Ports:
- b_clk_l  in  1  clock; all state updates on rising edge.
- reset_h  in  1  synchronous active-high reset.
- lookup_h  in  1  sample index_h/tag_in_h for a lookup this edge.
- index_h  in  INDEX_BITS  set index (physical address bits above longword).
- tag_in_h  in  TAG_BITS  tag for compare and for write.
- data_in_h  in  32  longword write data.
- cache_grp_wr_h  in  2  write strobe per group [1:0].
- cache_valid_h  in  2  valid bit written to the group being written.
- ena_byte_l  in  4  active-low byte write enables, applied to all written groups.
- flush_req_h  in  1  request full invalidate.
- data_out_h  out  32  data of the hitting group from the last lookup.
- hit_h  out  2  per-group hit from the last lookup.
- tag_par_err_h  out  2  per-group tag parity error from the last lookup.
- data_par_err_l  out  1  low = byte parity error in the hitting group's data.
- flush_busy_h  out  1  high while the sequencer invalidates.

Behaviour:
- Storage per group per set:
  - Tag, valid bit and tag parity bit. Tag parity = odd parity over {valid, tag}.
  - 4 data bytes, each with its own odd parity bit.
- Index register: `index_h` is captured on every edge where `lookup_h` or any `cache_grp_wr_h` bit is high.
- Write, at an edge with `cache_grp_wr_h[g]=1` and not flushing, for set `index_h`:
  - Tag, valid and tag parity are always written: tag = `tag_in_h`, valid = `cache_valid_h[g]`.
  - Data byte b and its parity are written only when `ena_byte_l[b]=0`.
- Both groups may be written in the same cycle.
- Lookup:
  - Read-before-write: a lookup and a write to the same set in the same edge return the pre-write contents.
  - One-cycle latency: registered results appear after the sampling edge.
  - Results hold until the next `lookup_h` edge.
  - Per group g:
    - `tag_par_err_h[g]` = valid & stored parity mismatch.
    - `hit_h[g]` = valid & tag equal & no tag parity error.
  - Both groups hitting: both `hit_h` bits are reported as-is; the control chip treats this as an error.
  - `data_out_h`: group 0 data if `hit_h[0]`, else group 1 data if `hit_h[1]`, else zero.
  - `data_par_err_l` = 0 iff a hitting group has any byte parity mismatch; 1 when there is no hit.
- Flush sequencer, states IDLE and FLUSH, with an INDEX_BITS counter:
  - `reset_h` forces FLUSH and counter=0. This also applies mid-flush: the flush restarts.
  - In FLUSH: each edge clears the valid bit of both groups in set = counter, then counter increments.
  - When counter = all-ones is cleared, the next state is IDLE and the counter wraps to 0.
  - In IDLE: `flush_req_h` moves to FLUSH with counter=0.
  - `flush_req_h` during FLUSH is ignored; no restart.
  - While in FLUSH: `flush_busy_h`=1, writes are ignored, and lookup results are forced to miss with no errors.
  - Flush duration: exactly 2**INDEX_BITS cycles.
- Reset values:
  - `hit_h`=00, `tag_par_err_h`=00, `data_par_err_l`=1, `data_out_h`=0, `flush_busy_h`=1.
  - RAM contents other than valid bits are undefined after reset.

Optional Feature:
CACHE_PAR_INJECT_EN
- Defined:
  - Adds input ports `inj_tag_par_h` [1:0] and `inj_data_par_h` [1:0].
  - While bit g is set, writes to group g store an inverted tag parity bit, or inverted parity on all written bytes, respectively.
  - Intended for diagnostic error-path testing.
- Undefined: the ports are absent and stored parity is always correct.

Test Plan:
- Flush: reset_h 1 cycle, INDEX_BITS=8 -> `flush_busy_h` high for 256 cycles; a lookup at any index then gives `hit_h`=00, `data_par_err_l`=1.
- Write/hit:
  - Write grp0 idx 0x12 tag 0x1ABC valid=1 data 0xDEADBEEF `ena_byte_l`=0000.
  - Lookup idx 0x12 tag 0x1ABC -> next cycle `hit_h`=01, `data_out_h`=0xDEADBEEF.
  - Lookup with tag 0x1ABD -> `hit_h`=00.
- Partial byte write:
  - Write grp1 idx 5 data 0x11223344, then write 0xAAAAAAAA with `ena_byte_l`=1010.
  - Lookup -> `hit_h`=10, `data_out_h`=0x11AA33AA.
- Read-before-write: same-edge lookup and write (valid=0) on a valid set -> `hit_h` shows the old hit; the next lookup misses.
- Parity inject (macro defined):
  - `inj_tag_par_h`=01 on a write -> lookup gives `tag_par_err_h`=01, `hit_h`=00.
  - `inj_data_par_h`=10 -> `hit_h`=10, `data_par_err_l`=0.
- Reset mid-flush: `flush_req_h` in IDLE, then reset_h at counter 100 -> flush restarts and `flush_busy_h` stays high 256 more cycles; writes during flush have no effect.
